// File: rtl/uart_frame_tx.sv
// uart_frame_tx: multi-byte UART frame transmitter.
// A word is latched when it is accepted. It is then sent one byte at a time,
// each byte as start, 8 data bits (LSB first), optional parity, and stop bits.
// Idle gap bit-times can be placed between bytes. A single baud counter runs
// without a break across the whole frame, so every bit lasts exactly
// BAUD_CNT_MAX clocks.
module uart_frame_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_WIDTH = 120,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int BYTE_ORDER = 0,
    parameter int GAP_BITS   = 0,
    localparam int BYTE_COUNT = (DATA_WIDTH + 7) / 8,
    localparam int IDX_W      = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_WIDTH-1:0] pi_data,
    input  logic                  pi_valid,
    output logic                  pi_ready,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [IDX_W-1:0]      byte_idx
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int BAUD_W       = $clog2(BAUD_CNT_MAX);
    localparam int PAD_W        = BYTE_COUNT * 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                     state_q, state_d;
    logic [BAUD_W-1:0]          baud_q, baud_d;
    logic [3:0]                 bit_q, bit_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       ready_q;
    logic [BYTE_COUNT-1:0][7:0] data_q;

    logic                       accept_s;
    logic                       bit_end_s;
    logic                       last_byte_s;
    logic [IDX_W-1:0]           sel_s;
    logic [7:0]                 cur_byte_s;
    logic [2:0]                 nxt_bit_s;

    // Parity of one byte; odd parity is the inverted XOR.
    function automatic logic parity_of(input logic [7:0] b);
        logic p;
        p = ^b;
        if (PARITY == 1) begin
            parity_of = ~p;
        end else begin
            parity_of = p;
        end
    endfunction

    assign accept_s    = pi_valid && ready_q;
    assign bit_end_s   = (baud_q == BAUD_W'(BAUD_CNT_MAX - 1));
    assign last_byte_s = (idx_q == IDX_W'(BYTE_COUNT - 1));
    assign nxt_bit_s   = bit_q[2:0] + 3'd1;
    assign sel_s       = (BYTE_ORDER == 1) ? (IDX_W'(BYTE_COUNT - 1) - idx_q) : idx_q;
    assign cur_byte_s  = data_q[sel_s];

    assign pi_ready = ready_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign byte_idx = idx_q;

    // Next-state, next line level and counter updates for the frame sequencer.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            baud_d = '0;
        end else if (bit_end_s) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                bit_d  = 4'd0;
                idx_d  = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept_s) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    bit_d   = 4'd0;
                    tx_d    = cur_byte_s[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_q[2:0] == 3'd7) begin
                        bit_d = 4'd0;
                        if (PARITY != 0) begin
                            state_d = ST_PAR;
                            tx_d    = parity_of(cur_byte_s);
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = cur_byte_s[nxt_bit_s];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PAR: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    bit_d   = 4'd0;
                    tx_d    = 1'b1;
                end else begin
                    state_d = ST_PAR;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = 4'd0;
                        if (last_byte_s) begin
                            // Frame complete: back to idle with a one-cycle done pulse.
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            idx_d   = '0;
                        end else if (GAP_BITS > 0) begin
                            state_d = ST_GAP;
                            tx_d    = 1'b1;
                        end else begin
                            state_d = ST_START;
                            idx_d   = idx_q + IDX_W'(1);
                            tx_d    = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_GAP: begin
                if (bit_end_s) begin
                    if (bit_q == 4'(GAP_BITS - 1)) begin
                        state_d = ST_START;
                        bit_d   = 4'd0;
                        idx_d   = idx_q + IDX_W'(1);
                        tx_d    = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = 4'd0;
                idx_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 4'd0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Payload latch: captured zero-extended on accept, held for the whole frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q <= '0;
        end else if (accept_s) begin
            data_q <= PAD_W'(pi_data);
        end else begin
            data_q <= data_q;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed testbench for uart_frame_tx. Five instances cover the parameter
// sets of interest; all use 10 clocks per bit.
module tb_uart_frame_tx;

    logic        clk;
    logic        rst_n;
    logic [11:0] data  [5];
    logic        valid [5];
    logic        txs   [5];
    logic        rdy   [5];
    logic        busy  [5];
    logic        done  [5];
    logic [0:0]  idx   [5];

    int          checks;
    int          failures;
    logic [63:0] exp_bits;
    int          exp_n;

    // 0: 12b none/1 stop; 1: even parity; 2: odd parity; 3: msb-first 2 stop 2 gap; 4: 1b even
    uart_frame_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_WIDTH(12), .PARITY(0),
                    .STOP_BITS(1), .BYTE_ORDER(0), .GAP_BITS(0)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[0]), .pi_valid(valid[0]),
        .pi_ready(rdy[0]), .tx(txs[0]), .tx_busy(busy[0]), .tx_done(done[0]), .byte_idx(idx[0]));
    uart_frame_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_WIDTH(12), .PARITY(2),
                    .STOP_BITS(1), .BYTE_ORDER(0), .GAP_BITS(0)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[1]), .pi_valid(valid[1]),
        .pi_ready(rdy[1]), .tx(txs[1]), .tx_busy(busy[1]), .tx_done(done[1]), .byte_idx(idx[1]));
    uart_frame_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_WIDTH(12), .PARITY(1),
                    .STOP_BITS(1), .BYTE_ORDER(0), .GAP_BITS(0)) u_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[2]), .pi_valid(valid[2]),
        .pi_ready(rdy[2]), .tx(txs[2]), .tx_busy(busy[2]), .tx_done(done[2]), .byte_idx(idx[2]));
    uart_frame_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_WIDTH(12), .PARITY(0),
                    .STOP_BITS(2), .BYTE_ORDER(1), .GAP_BITS(2)) u_d (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[3]), .pi_valid(valid[3]),
        .pi_ready(rdy[3]), .tx(txs[3]), .tx_busy(busy[3]), .tx_done(done[3]), .byte_idx(idx[3]));
    uart_frame_tx #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_WIDTH(1), .PARITY(2),
                    .STOP_BITS(1), .BYTE_ORDER(0), .GAP_BITS(0)) u_e (
        .sys_clk(clk), .sys_rst_n(rst_n), .pi_data(data[4][0:0]), .pi_valid(valid[4]),
        .pi_ready(rdy[4]), .tx(txs[4]), .tx_busy(busy[4]), .tx_done(done[4]), .byte_idx(idx[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Append one byte's expected line bits (start, data LSB first, parity, stops, gap).
    task automatic push_byte(input logic [7:0] b, input bit has_par, input logic pb,
                             input int stops, input int gap);
        exp_bits[exp_n] = 1'b0; exp_n++;
        for (int i = 0; i < 8; i++) begin exp_bits[exp_n] = b[i]; exp_n++; end
        if (has_par) begin exp_bits[exp_n] = pb; exp_n++; end
        for (int i = 0; i < stops + gap; i++) begin exp_bits[exp_n] = 1'b1; exp_n++; end
    endtask

    task automatic clear_exp();
        exp_bits = 64'd0;
        exp_n    = 0;
    endtask

    // Present a word for one accept edge.
    task automatic start(input int d, input logic [11:0] w);
        @(negedge clk);
        data[d]  = w;
        valid[d] = 1'b1;
        @(posedge clk);
    endtask

    // Record a frame that was accepted on the last rising edge: mid-bit line
    // samples, byte_idx per bit, length in clocks until tx_done, and whether
    // busy/ready held their in-frame values. Optionally changes inputs mid-frame.
    task automatic capture(input int d, input bit hold, input int mid_cnt,
                           input logic [11:0] mid_data, input logic mid_valid,
                           output logic [63:0] bits, output logic [63:0] idxb,
                           output int len, output logic tx0,
                           output logic flags_ok, output logic end_ok);
        bits = 64'd0; idxb = 64'd0; len = -1; tx0 = 1'b1; flags_ok = 1'b1; end_ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (c == 0) begin valid[d] = hold; tx0 = txs[d]; end
            if (c == mid_cnt) begin data[d] = mid_data; valid[d] = mid_valid; end
            if (done[d]) begin
                len    = c;
                end_ok = !busy[d] && rdy[d];
                break;
            end
            if ((c % 10 == 5) && (c < 640)) begin
                bits[c/10] = txs[d];
                idxb[c/10] = idx[d][0];
            end
            if (!busy[d] || rdy[d]) flags_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 5; d++) begin
            checks++;
            if ({txs[d], rdy[d], busy[d], done[d], idx[d]} !== 5'b11000) begin
                failures++;
                $display("FAIL reset_state dut%0d: got %b expected 11000", d,
                         {txs[d], rdy[d], busy[d], done[d], idx[d]});
            end
        end
    endtask

    task automatic test_basic();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok;
        clear_exp();
        push_byte(8'h5C, 1'b0, 1'b0, 1, 0);
        push_byte(8'h0A, 1'b0, 1'b0, 1, 0);
        start(0, 12'hA5C);
        capture(0, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (tx0 !== 1'b0) begin failures++; $display("FAIL basic_start_latency: got %b expected 0", tx0); end
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL basic_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 200) begin failures++; $display("FAIL basic_len: got %0d expected 200", len); end
        checks++; if (fok !== 1'b1) begin failures++; $display("FAIL basic_busy_ready: got %b expected 1", fok); end
        checks++; if (eok !== 1'b1) begin failures++; $display("FAIL basic_done_cycle: got %b expected 1", eok); end
        checks++; if (idxb !== 64'h0000_0000_000F_FC00) begin failures++; $display("FAIL basic_idx: got %h expected 00000000000ffc00", idxb); end
        @(negedge clk);
        checks++; if ({done[0], txs[0]} !== 2'b01) begin failures++; $display("FAIL basic_done_pulse: got %b expected 01", {done[0], txs[0]}); end
    endtask

    task automatic test_parity();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok;
        clear_exp();
        push_byte(8'h5C, 1'b1, 1'b0, 1, 0);
        push_byte(8'h0A, 1'b1, 1'b0, 1, 0);
        start(1, 12'hA5C);
        capture(1, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL even_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 220) begin failures++; $display("FAIL even_len: got %0d expected 220", len); end
        clear_exp();
        push_byte(8'h5C, 1'b1, 1'b1, 1, 0);
        push_byte(8'h0A, 1'b1, 1'b1, 1, 0);
        start(2, 12'hA5C);
        capture(2, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL odd_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 220) begin failures++; $display("FAIL odd_len: got %0d expected 220", len); end
    endtask

    task automatic test_order_gap();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok;
        clear_exp();
        push_byte(8'h0A, 1'b0, 1'b0, 2, 2);
        push_byte(8'h5C, 1'b0, 1'b0, 2, 0);
        start(3, 12'hA5C);
        capture(3, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL order_gap_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 240) begin failures++; $display("FAIL order_gap_len: got %0d expected 240", len); end
        checks++; if (idxb !== 64'h0000_0000_00FF_E000) begin failures++; $display("FAIL order_gap_idx: got %h expected 0000000000ffe000", idxb); end
        checks++; if (fok !== 1'b1) begin failures++; $display("FAIL order_gap_busy: got %b expected 1", fok); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok;
        clear_exp();
        push_byte(8'h01, 1'b0, 1'b0, 1, 0);
        push_byte(8'h00, 1'b0, 1'b0, 1, 0);
        start(0, 12'h001);
        capture(0, 1'b1, 50, 12'h0FF, 1'b1, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL b2b_first_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (fok !== 1'b1) begin failures++; $display("FAIL b2b_ready_low: got %b expected 1", fok); end
        checks++; if (eok !== 1'b1) begin failures++; $display("FAIL b2b_done_cycle: got %b expected 1", eok); end
        clear_exp();
        push_byte(8'hFF, 1'b0, 1'b0, 1, 0);
        push_byte(8'h00, 1'b0, 1'b0, 1, 0);
        capture(0, 1'b0, 50, 12'h3C3, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (tx0 !== 1'b0) begin failures++; $display("FAIL b2b_second_start: got %b expected 0", tx0); end
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL b2b_second_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 200) begin failures++; $display("FAIL b2b_second_len: got %0d expected 200", len); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok; logic quiet;
        start(0, 12'hA5C);
        #1 valid[0] = 1'b0;
        repeat (55) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({txs[0], busy[0], rdy[0], done[0], idx[0]} !== 5'b10100) begin
            failures++;
            $display("FAIL midreset_state: got %b expected 10100", {txs[0], busy[0], rdy[0], done[0], idx[0]});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done[0] || !txs[0] || busy[0]) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL midreset_no_resume: got %b expected 1", quiet); end
        clear_exp();
        push_byte(8'hA3, 1'b0, 1'b0, 1, 0);
        push_byte(8'h05, 1'b0, 1'b0, 1, 0);
        start(0, 12'h5A3);
        capture(0, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL midreset_new_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 200) begin failures++; $display("FAIL midreset_new_len: got %0d expected 200", len); end
    endtask

    task automatic test_narrow();
        logic [63:0] bits, idxb; int len; logic tx0, fok, eok;
        clear_exp();
        push_byte(8'h01, 1'b1, 1'b1, 1, 0);
        start(4, 12'h001);
        capture(4, 1'b0, -1, 12'h000, 1'b0, bits, idxb, len, tx0, fok, eok);
        checks++; if (bits !== exp_bits) begin failures++; $display("FAIL narrow_bits: got %h expected %h", bits, exp_bits); end
        checks++; if (len !== 110) begin failures++; $display("FAIL narrow_len: got %0d expected 110", len); end
        checks++; if (idxb !== 64'd0) begin failures++; $display("FAIL narrow_idx: got %h expected 0", idxb); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 5; d++) begin
            data[d]  = 12'h000;
            valid[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        test_basic();
        test_parity();
        test_order_gap();
        test_back_to_back();
        test_reset_midframe();
        test_narrow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised multi-byte UART frame transmitter. It is the successor to the fixed 8N1 transmit pump and is used to stream wide status/command words from the arm controller to the host link. Each accepted word is latched at acceptance and serialised byte-by-byte. Parity, stop-bit count, byte order and inter-byte idle gap are all configurable. Upstream logic sees a ready/valid handshake plus busy and done indications.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS clocks per bit (integer division, must be >= 4)
DATA_WIDTH, 120, payload width in bits (>= 1); BYTE_COUNT = ceil(DATA_WIDTH/8)
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
BYTE_ORDER, 0, 0 = byte 0 (bits 7:0) sent first; 1 = highest byte sent first
GAP_BITS, 0, idle (high) bit-times inserted between bytes, 0..15; never inserted after the last byte

Ports:
sys_clk  in  1  system clock, rising edge
sys_rst_n  in  1  asynchronous active-low reset
pi_data  in  DATA_WIDTH  payload; sampled only on the accept cycle
pi_valid  in  1  request to send pi_data
pi_ready  out  1  high in IDLE; accept = pi_valid && pi_ready
tx  out  1  serial line, idle high
tx_busy  out  1  high from the cycle after accept until the frame completes
tx_done  out  1  one-cycle pulse at frame completion
byte_idx  out  max(1,$clog2(BYTE_COUNT))  position (0-based, in send order) of the byte currently on the line

Behaviour:
- Reset (async assert, sync-to-clock deassert use): tx=1, pi_ready=1, tx_busy=0, tx_done=0, byte_idx=0; state IDLE; counters cleared. Asserting reset mid-frame forces tx high immediately and drops the frame; nothing is resumed.
- States: IDLE, START, DATA, PAR, STOP, GAP.
- IDLE -> START on accept. On the accept edge the block latches pi_data zero-extended to BYTE_COUNT*8 bits; later changes to pi_data have no effect.
- tx goes low on the first clock edge after accept, i.e. registered with 1 cycle latency.
- Every bit (start, data, parity, stop, gap) holds tx for exactly BAUD_CNT_MAX clocks. The baud counter runs continuously through the frame and does not restart per byte.
- START -> DATA: 8 data bits, LSB of the byte first.
- DATA -> PAR if PARITY != 0, else -> STOP. Parity bit = XOR of the 8 data bits; this value is inverted for odd parity.
- STOP: STOP_BITS bit-times of tx=1.
- After STOP:
  - if this is not the last byte and GAP_BITS > 0 -> GAP (GAP_BITS bit-times, tx=1), then -> START;
  - if this is not the last byte and GAP_BITS = 0 -> START;
  - if this is the last byte -> IDLE.
- byte_idx increments at the transition into START of the next byte; it wraps to 0 on return to IDLE.
- Byte selection: send position k maps to byte k when BYTE_ORDER=0, and to byte BYTE_COUNT-1-k when BYTE_ORDER=1.
- Frame length: BYTE_COUNT*(10+P+STOP_BITS-1)*BAUD_CNT_MAX + (BYTE_COUNT-1)*GAP_BITS*BAUD_CNT_MAX clocks, where P = 1 if PARITY != 0, else 0.
- Completion: on the edge that ends the last stop bit, the block enters IDLE, tx_done=1 for exactly 1 cycle, tx_busy=0 and pi_ready=1 in that same cycle.
- Back-to-back: pi_valid held high in the tx_done cycle is accepted. The next start bit begins the following cycle, so the line has zero extra idle.
- pi_valid while busy is ignored; no queueing, and pi_ready stays low.
- Padding bits above DATA_WIDTH are sent as 0 and are included in the parity computation.

Test Plan:
1. Sim params CLK_FREQ=1000, UART_BPS=100 (BAUD=10), DATA_WIDTH=12, PARITY=0, STOP_BITS=1. Send 0xA5C -> tx low 1 cycle after accept. Byte 0x5C bits 0,0,1,1,1,0,1,0, stop, then byte 0x0A. tx_done pulses exactly 200 cycles after tx first falls; tx_busy high throughout.
2. Same data with PARITY=2 -> parity bits 0 (0x5C) and 0 (0x0A); frame 220 cycles. With PARITY=1 -> parity bits 1 and 1.
3. BYTE_ORDER=1, STOP_BITS=2, GAP_BITS=2, data 0xA5C -> 0x0A sent first, then 0x5C. tx high for 40 cycles between the two start bits (stop+gap). Frame 240 cycles; byte_idx 0 then 1.
4. Back-to-back: pi_valid held high with 0x001 then 0x0FF -> second start bit begins the cycle after tx_done. pi_data changes mid-frame are not transmitted. pi_ready is low during the frame.
5. Assert sys_rst_n low at cycle 55 of a frame -> tx=1, tx_busy=0 immediately, no tx_done. After release, a new accept produces a complete, correct frame.
6. DATA_WIDTH=1, data 1, PARITY=2 -> single byte 0x01, parity bit 1, frame 110 cycles.
